// File: rtl/look_ahead_pkg.sv
// Shared constants and the flattened 4-bit carry-lookahead equations.
package look_ahead_pkg;

  localparam int unsigned GRP_W = 4;

  // Intra-group carries c1..c3 as flat sum-of-products, no ripple.
  function automatic logic [3:1] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       c0);
    logic [3:1] c;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/look_ahead_cla_block_4.sv
// 4-bit lookahead cell: sum plus group propagate/generate for the next level.
module cla_block_4
  import look_ahead_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:1] c;

  // Bit propagate/generate and flattened intra-group carries.
  assign p = a ^ b;
  assign g = a & b;
  assign c = cla4_carries(g, p, cin);

  // Sum bits and group terms exported to the second lookahead level.
  assign s  = p ^ {c[3:1], cin};
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/look_ahead.sv
// Two-level carry-lookahead adder with combinational and registered results.
module look_ahead
  import look_ahead_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             P_grp,
  output logic             G_grp,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q
);

  localparam int unsigned NGRP = WIDTH / GRP_W;

  if (WIDTH % GRP_W != 0) begin : g_width_check
    $error("look_ahead: WIDTH must be a multiple of 4");
  end

  logic [NGRP-1:0] pg;
  logic [NGRP-1:0] gg;
  logic [NGRP:0]   gc;
  logic            c_acc;
  logic            c_prod;
  logic            g_acc;
  logic            g_prod;

  // One lookahead cell per 4-bit slice; carry-in from the second level.
  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla_block_4 u_blk (
      .a  (A[GRP_W*i +: GRP_W]),
      .b  (B[GRP_W*i +: GRP_W]),
      .cin(gc[i]),
      .s  (S[GRP_W*i +: GRP_W]),
      .pg (pg[i]),
      .gg (gg[i])
    );
  end

  // Second level: each group carry-in as a flat OR of generate/propagate products.
  always_comb begin
    gc     = '0;
    c_acc  = 1'b0;
    c_prod = 1'b0;
    for (int k = 0; k <= int'(NGRP); k++) begin
      c_acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        c_prod = gg[j];
        for (int m = j + 1; m < k; m++) c_prod = c_prod & pg[m];
        c_acc = c_acc | c_prod;
      end
      c_prod = Cin;
      for (int m = 0; m < k; m++) c_prod = c_prod & pg[m];
      gc[k] = c_acc | c_prod;
    end
  end

  // Top-level group generate, independent of Cin.
  always_comb begin
    g_acc  = 1'b0;
    g_prod = 1'b0;
    for (int j = 0; j < int'(NGRP); j++) begin
      g_prod = gg[j];
      for (int m = j + 1; m < int'(NGRP); m++) g_prod = g_prod & pg[m];
      g_acc = g_acc | g_prod;
    end
  end

  assign Cout  = gc[NGRP];
  assign P_grp = &pg;
  assign G_grp = g_acc;

  // Registered copy of the result; reset has priority over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q    <= '0;
      Cout_q <= 1'b0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_look_ahead.sv
// Directed checks of the 4-bit and 16-bit lookahead adder.
module tb_look_ahead;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a, b, s, s_q;
  logic        cin, cout, p_grp, g_grp, cout_q;
  logic [15:0] a16, b16, s16, s16_q;
  logic        cin16, cout16, p16, g16, cout16_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  look_ahead #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin),
    .S(s), .Cout(cout), .P_grp(p_grp), .G_grp(g_grp),
    .S_q(s_q), .Cout_q(cout_q)
  );

  look_ahead #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16),
    .S(s16), .Cout(cout16), .P_grp(p16), .G_grp(g16),
    .S_q(s16_q), .Cout_q(cout16_q)
  );

  // Reset held two edges clears the registered outputs.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; a = 4'd7; b = 4'd12; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cout_q, s_q} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %0d want 0", {cout_q, s_q});
    end
    n_checks++;
    if ({cout, s} !== 5'd20) begin
      n_fail++;
      $display("FAIL reset_comb: got %0d want 20", {cout, s});
    end
  endtask

  // Hand-computed small sums; combinational now, registered one edge later.
  task automatic test_sequence();
    logic [3:0] va[12] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd8, 4'd5, 4'd5, 4'd2, 4'd2, 4'd3, 4'd3, 4'd10};
    logic [3:0] vb[12] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd4, 4'd10, 4'd0, 4'd0, 4'd4};
    logic       vc[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] vs[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd9, 4'd6, 4'd12, 4'd3, 4'd4, 4'd15};
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; cin = vc[i];
      #1;
      n_checks++;
      if ({cout, s} !== {1'b0, vs[i]}) begin
        n_fail++;
        $display("FAIL seq_comb[%0d]: got %0d want %0d", i, {cout, s}, vs[i]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({cout_q, s_q} !== {1'b0, vs[i]}) begin
        n_fail++;
        $display("FAIL seq_reg[%0d]: got %0d want %0d", i, {cout_q, s_q}, vs[i]);
      end
    end
  endtask

  // Full carry propagation and all-ones wrap.
  task automatic test_carry_chain();
    @(negedge clk);
    a = 4'hF; b = 4'h0; cin = 1'b1;
    #1;
    n_checks++;
    if ({cout, s, p_grp, g_grp} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL chain_prop: got cout=%b s=%h p=%b g=%b want 1 0 1 0", cout, s, p_grp, g_grp);
    end
    a = 4'hF; b = 4'hF; cin = 1'b1;
    #1;
    n_checks++;
    if ({cout, s, g_grp} !== {1'b1, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL chain_wrap: got cout=%b s=%h g=%b want 1 f 1", cout, s, g_grp);
    end
  endtask

  // Every 4-bit operand/carry combination, including group P/G consistency.
  task automatic test_exhaustive();
    logic [4:0] exp_sum;
    logic       exp_p, exp_g;
    int         bad = 0;
    for (int i = 0; i < 512; i++) begin
      a   = 4'(i);
      b   = 4'(i >> 4);
      cin = 1'(i >> 8);
      #1;
      exp_sum = 5'(a) + 5'(b) + 5'(cin);
      exp_p   = &(a ^ b);
      exp_g   = (5'(a) + 5'(b)) > 5'd15;
      n_checks++;
      if ({cout, s, p_grp, g_grp} !== {exp_sum, exp_p, exp_g}) begin
        n_fail++;
        bad++;
        if (bad <= 8)
          $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got sum=%0d p=%b g=%b want sum=%0d p=%b g=%b",
                   a, b, cin, {cout, s}, p_grp, g_grp, exp_sum, exp_p, exp_g);
      end
    end
  endtask

  // Registered path across reset, release, and mid-stream reset.
  task automatic test_registered();
    @(negedge clk);
    rst = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cout_q, s_q} !== 5'd0) begin
      n_fail++;
      $display("FAIL reg_hold: got %0d want 0", {cout_q, s_q});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout_q, s_q} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL reg_release: got cout_q=%b s_q=%0d want 1 2", cout_q, s_q);
    end
    @(negedge clk);
    a = 4'd6; b = 4'd3; cin = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout_q, s_q} !== {1'b0, 4'd10}) begin
      n_fail++;
      $display("FAIL reg_stream: got cout_q=%b s_q=%0d want 0 10", cout_q, s_q);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout_q, s_q, cout, s} !== {1'b0, 4'd0, 1'b0, 4'd10}) begin
      n_fail++;
      $display("FAIL reg_midreset: got q=%0d comb=%0d want q=0 comb=10", {cout_q, s_q}, {cout, s});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 16-bit instance: full chain plus random vectors against arithmetic.
  task automatic test_wide();
    logic [16:0] exp17;
    int          bad = 0;
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    #1;
    n_checks++;
    if ({cout16, s16, p16, g16} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wide_chain: got cout=%b s=%h p=%b g=%b want 1 0000 1 0", cout16, s16, p16, g16);
    end
    a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0;
    #1;
    n_checks++;
    if ({cout16, s16, g16} !== {1'b1, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_msb: got cout=%b s=%h g=%b want 1 0000 1", cout16, s16, g16);
    end
    for (int i = 0; i < 1000; i++) begin
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom);
      #1;
      exp17 = 17'(a16) + 17'(b16) + 17'(cin16);
      n_checks++;
      if ({cout16, s16} !== exp17) begin
        n_fail++;
        bad++;
        if (bad <= 8)
          $display("FAIL wide_rand a=%h b=%h cin=%b: got %h want %h", a16, b16, cin16, {cout16, s16}, exp17);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_sequence();
    test_carry_chain();
    test_exhaustive();
    test_registered();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
